// File: rtl/fpu_add_sub_operand_stage.sv
// Operand unpack/classify stage for the single-precision add/sub path.
// Two-entry in-order skid buffer; classification is captured with each entry.
module fpu_add_sub_operand_stage #(
  parameter bit FTZ = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        sub_op_i,
  input  logic [2:0]  rounding_mode_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        sign_A_o,
  output logic        sign_B_o,
  output logic [7:0]  exp_A_o,
  output logic [7:0]  exp_B_o,
  output logic [22:0] sig_A_o,
  output logic [22:0] sig_B_o,
  output logic        sub_op_o,
  output logic [2:0]  rounding_mode_o,
  output logic        isZeroA_o,
  output logic        isZeroB_o,
  output logic        isInfA_o,
  output logic        isInfB_o,
  output logic        isNaNA_o,
  output logic        isNaNB_o,
  output logic        isSubA_o,
  output logic        isSubB_o,
  output logic        isSignaling_o,
  output logic        illegal_rm_o
);

  typedef struct packed {
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [22:0] sig_a;
    logic [22:0] sig_b;
    logic        sub_op;
    logic [2:0]  rm;
    logic        zero_a;
    logic        zero_b;
    logic        inf_a;
    logic        inf_b;
    logic        nan_a;
    logic        nan_b;
    logic        sub_a;
    logic        sub_b;
    logic        signaling;
    logic        illegal_rm;
  } entry_t;

  entry_t     in_entry;
  entry_t     head;
  entry_t     mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  logic a_exp_zero, a_exp_max, a_sig_zero;
  logic b_exp_zero, b_exp_max, b_sig_zero;

  always_comb begin
    a_exp_zero = (op_a_i[30:23] == 8'h00);
    a_exp_max  = (op_a_i[30:23] == 8'hFF);
    a_sig_zero = (op_a_i[22:0] == 23'd0);
    b_exp_zero = (op_b_i[30:23] == 8'h00);
    b_exp_max  = (op_b_i[30:23] == 8'hFF);
    b_sig_zero = (op_b_i[22:0] == 23'd0);

    in_entry        = '0;
    in_entry.sign_a = op_a_i[31];
    in_entry.sign_b = op_b_i[31];
    in_entry.exp_a  = op_a_i[30:23];
    in_entry.exp_b  = op_b_i[30:23];
    // Flushed subnormals present a clean zero significand downstream.
    in_entry.sig_a  = (FTZ && a_exp_zero) ? 23'd0 : op_a_i[22:0];
    in_entry.sig_b  = (FTZ && b_exp_zero) ? 23'd0 : op_b_i[22:0];
    in_entry.sub_op = sub_op_i;
    in_entry.rm     = rounding_mode_i;

    in_entry.zero_a = a_exp_zero && (a_sig_zero || FTZ);
    in_entry.zero_b = b_exp_zero && (b_sig_zero || FTZ);
    in_entry.sub_a  = a_exp_zero && !a_sig_zero && !FTZ;
    in_entry.sub_b  = b_exp_zero && !b_sig_zero && !FTZ;
    in_entry.inf_a  = a_exp_max && a_sig_zero;
    in_entry.inf_b  = b_exp_max && b_sig_zero;
    in_entry.nan_a  = a_exp_max && !a_sig_zero;
    in_entry.nan_b  = b_exp_max && !b_sig_zero;

    in_entry.signaling  = (in_entry.nan_a && !op_a_i[22]) ||
                          (in_entry.nan_b && !op_b_i[22]);
    in_entry.illegal_rm = (rounding_mode_i >= 3'b101);
  end

  // Handshake flags come only from the registered count.
  assign in_ready_o  = (count != 2'd2);
  assign out_valid_o = (count != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

  assign sign_A_o        = head.sign_a;
  assign sign_B_o        = head.sign_b;
  assign exp_A_o         = head.exp_a;
  assign exp_B_o         = head.exp_b;
  assign sig_A_o         = head.sig_a;
  assign sig_B_o         = head.sig_b;
  assign sub_op_o        = head.sub_op;
  assign rounding_mode_o = head.rm;
  assign isZeroA_o       = head.zero_a;
  assign isZeroB_o       = head.zero_b;
  assign isInfA_o        = head.inf_a;
  assign isInfB_o        = head.inf_b;
  assign isNaNA_o        = head.nan_a;
  assign isNaNB_o        = head.nan_b;
  assign isSubA_o        = head.sub_a;
  assign isSubB_o        = head.sub_b;
  assign isSignaling_o   = head.signaling;
  assign illegal_rm_o    = head.illegal_rm;

endmodule

// File: doc/fpu_add_sub_operand_stage.md
FPU_ADD_SUB_OPERAND_STAGE -- requirements
Module: fpu_add_sub_operand_stage

Interface
REQ-001 SHALL have parameter FTZ, default 0; when 1, subnormal inputs are classified as zero.
REQ-002 SHALL have ports clk_i, input, 1, the only clock.
REQ-003 SHALL have port reset_i, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports in_valid_i (in, 1) and in_ready_o (out, 1) forming the upstream handshake.
REQ-005 SHALL have ports op_a_i and op_b_i (in, 32 each), carrying raw IEEE-754 single operands.
REQ-006 SHALL have ports sub_op_i (in, 1) and rounding_mode_i (in, 3).
REQ-007 SHALL have port flush_i (in, 1), a synchronous kill of all buffered entries.
REQ-008 SHALL have ports out_valid_o (out, 1) and out_ready_i (in, 1) forming the downstream handshake to the add/sub fast-path and main datapath.
REQ-009 SHALL have ports sign_A_o and sign_B_o (out, 1), exp_A_o and exp_B_o (out, 8), sig_A_o and sig_B_o (out, 23), sub_op_o (out, 1), and rounding_mode_o (out, 3).
REQ-010 SHALL have ports isZeroA_o, isZeroB_o, isInfA_o, isInfB_o, isNaNA_o, isNaNB_o, isSubA_o, isSubB_o, isSignaling_o and illegal_rm_o (out, 1 each).

Function
REQ-011 SHALL implement a 2-entry in-order buffer with a registered occupancy count of 0..2.
REQ-012 SHALL drive in_ready_o = (count < 2) from registered state only, with no combinational path from out_ready_i.
REQ-013 SHALL push on in_valid_i & in_ready_o and pop on out_valid_o & out_ready_i; the count changes by push minus pop.
REQ-014 SHALL allow a simultaneous push and pop at count 1, leaving count at 1 and presenting the next entry in order.
REQ-015 SHALL give latency 1: an entry accepted at edge N is visible on out_valid_o after edge N, when the buffer was empty.
REQ-016 SHALL drive out_valid_o = (count > 0); all output fields reflect the head entry and hold stable while out_valid_o & !out_ready_i.
REQ-017 SHALL register classification with the entry, so no output depends combinationally on op_*_i.
REQ-018 SHALL compute, per operand: sign = bit31; exp = bits30:23; sig = bits22:0.
REQ-019 SHALL compute isZero = (exp==0 & sig==0), or with FTZ=1 (exp==0).
REQ-020 SHALL compute isSub = (exp==0 & sig!=0 & FTZ==0).
REQ-021 SHALL compute isInf = (exp==255 & sig==0) and isNaN = (exp==255 & sig!=0).
REQ-022 SHALL keep isZero, isSub, isInf and isNaN mutually exclusive per operand.
REQ-023 SHALL compute isSignaling = (isNaNA & !sig_A[22]) | (isNaNB & !sig_B[22]).
REQ-024 SHALL set illegal_rm_o when rounding_mode is 101, 110 or 111; the entry still passes through unchanged.
REQ-025 SHALL, with FTZ=1 and a subnormal input, output sig = 0 for that operand while preserving sign.
REQ-026 SHALL, on flush_i, set count to 0 at the next edge; flush overrides a same-cycle push and pop, and the flushed entries are never presented.
REQ-027 SHALL make a pop at count 2 raise in_ready_o after that edge, not in the same cycle.
REQ-028 SHALL never write when full: in_valid_i at count 2 is ignored and the upstream holds its data.

Reset
REQ-029 SHALL, while reset_i=1, asynchronously force count=0, out_valid_o=0 and in_ready_o=1, and clear all stored fields and flags to 0.
REQ-030 SHALL discard any in-flight entries on reset asserted mid-operation, with no output pulse on release.
REQ-031 SHALL accept a push on the first rising edge after reset_i deasserts.

Verification
REQ-032 SHALL cover: push A=0x3F800000, B=0x7F800000, out_ready_i=1 -> next cycle out_valid_o=1, isInfB_o=1, exp_A_o=0x7F, sig_A_o=0, all other flags 0.
REQ-033 SHALL cover: push A=0x7F800001, B=0x00000000 -> isNaNA_o=1, isSignaling_o=1, isZeroB_o=1; and A=0x7FC00000 -> isSignaling_o=0.
REQ-034 SHALL cover: B=0x00000001 with FTZ=0 -> isSubB_o=1; with FTZ=1 -> isZeroB_o=1, sig_B_o=0.
REQ-035 SHALL cover: out_ready_i=0 with 3 pushes offered -> 2 accepted, in_ready_o=0, head stable; then out_ready_i=1 -> entries emerge in order and in_ready_o rises one cycle after the first pop.
REQ-036 SHALL cover: count=2 with flush_i=1 and in_valid_i=1 in the same cycle -> next cycle count=0, out_valid_o=0, in_ready_o=1.
REQ-037 SHALL cover: rounding_mode_i=3'b101 -> illegal_rm_o=1 and rounding_mode_o=101; reset_i pulsed mid-stream -> out_valid_o=0 immediately.
